ffwd_ctrl: RTL and testbench



---
 rtl/ffwd_ctrl.sv | 152 +++++++++++++++
 tb/tb_ffwd_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ffwd_ctrl.sv
// Forward-pass sequencer: layer-1 MAC, activation, bank capture, layer-2 MAC.
// A single shared down-counter times every state; outputs are registered.
module ffwd_ctrl #(
  parameter int L1_TERMS    = 2,
  parameter int L2_TERMS    = 3,
  parameter int MAC_LATENCY = 2,
  parameter int LUT_LATENCY = 1,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ACC_CLR,
  output logic                  ACC_EN,
  output logic                  WRITE_EN,
  output logic                  LAYER_SEL,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  output logic [ADDR_WIDTH-1:0] BANK_ADDR
);

  if (L1_TERMS + L2_TERMS > (1 << ADDR_WIDTH)) begin : g_addr_chk
    $error("ffwd_ctrl: L1_TERMS+L2_TERMS exceeds the address space");
  end

  localparam int CW = 4;
  localparam logic [ADDR_WIDTH-1:0] L1A = ADDR_WIDTH'(L1_TERMS);
  localparam logic [ADDR_WIDTH-1:0] L2A = ADDR_WIDTH'(L2_TERMS);

  typedef enum logic [3:0] {
    S_IDLE, S_L1_CLR, S_L1_MAC, S_L1_DRAIN, S_ACT_WAIT, S_WRITE,
    S_L2_CLR, S_L2_MAC, S_L2_DRAIN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_d, done_d, clr_d, en_d, we_d, sel_d;
  logic [ADDR_WIDTH-1:0] rom_d, bank_d;

  // Zero-length states are resolved here, so they are never entered.
  function automatic state_e succ(input state_e s);
    case (s)
      S_L1_CLR:   succ = S_L1_MAC;
      S_L1_MAC:   succ = (MAC_LATENCY > 0) ? S_L1_DRAIN :
                         (LUT_LATENCY > 0) ? S_ACT_WAIT : S_WRITE;
      S_L1_DRAIN: succ = (LUT_LATENCY > 0) ? S_ACT_WAIT : S_WRITE;
      S_ACT_WAIT: succ = S_WRITE;
      S_WRITE:    succ = S_L2_CLR;
      S_L2_CLR:   succ = S_L2_MAC;
      S_L2_MAC:   succ = (MAC_LATENCY > 0) ? S_L2_DRAIN : S_DONE;
      S_L2_DRAIN: succ = S_DONE;
      default:    succ = S_IDLE;
    endcase
  endfunction

  function automatic logic [CW-1:0] dur(input state_e s);
    case (s)
      S_L1_MAC:   dur = CW'(L1_TERMS);
      S_L1_DRAIN: dur = CW'(MAC_LATENCY);
      S_ACT_WAIT: dur = CW'(LUT_LATENCY);
      S_L2_MAC:   dur = CW'(L2_TERMS);
      S_L2_DRAIN: dur = CW'(MAC_LATENCY);
      default:    dur = CW'(1);
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ACC_CLR   <= 1'b0;
      ACC_EN    <= 1'b0;
      WRITE_EN  <= 1'b0;
      LAYER_SEL <= 1'b0;
      ROM_ADDR  <= '0;
      BANK_ADDR <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ACC_CLR   <= clr_d;
      ACC_EN    <= en_d;
      WRITE_EN  <= we_d;
      LAYER_SEL <= sel_d;
      ROM_ADDR  <= rom_d;
      BANK_ADDR <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_L1_CLR;
          cnt_d   = dur(S_L1_CLR);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q <= CW'(1)) begin
          state_d = succ(state_q);
          cnt_d   = dur(succ(state_q));
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // Decoded from the next state so the registered outputs line up with state_q.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    clr_d  = 1'b0;
    en_d   = 1'b0;
    we_d   = 1'b0;
    sel_d  = 1'b0;
    rom_d  = '0;
    bank_d = '0;
    case (state_d)
      S_L1_CLR:   begin busy_d = 1'b1; clr_d = 1'b1; end
      S_L1_MAC: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
        rom_d  = L1A - ADDR_WIDTH'(cnt_d);
      end
      S_L1_DRAIN: busy_d = 1'b1;
      S_ACT_WAIT: busy_d = 1'b1;
      S_WRITE:    begin busy_d = 1'b1; we_d = 1'b1; end
      S_L2_CLR:   begin busy_d = 1'b1; clr_d = 1'b1; sel_d = 1'b1; end
      S_L2_MAC: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
        sel_d  = 1'b1;
        bank_d = L2A - ADDR_WIDTH'(cnt_d);
        rom_d  = L1A + L2A - ADDR_WIDTH'(cnt_d);
      end
      S_L2_DRAIN: begin busy_d = 1'b1; sel_d = 1'b1; end
      S_DONE:     begin done_d = 1'b1; sel_d = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ffwd_ctrl.sv
// Randomized bench for ffwd_ctrl: default and minimal configurations side by side
// against a pass-offset model.
module tb_ffwd_ctrl;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic a_busy, a_done, a_clr, a_en, a_we, a_sel;
  logic [3:0] a_rom, a_bank;
  logic b_busy, b_done, b_clr, b_en, b_we, b_sel;
  logic [3:0] b_rom, b_bank;
  logic [13:0] obs [2];

  assign obs[0] = {a_busy, a_done, a_clr, a_en, a_we, a_sel, a_rom, a_bank};
  assign obs[1] = {b_busy, b_done, b_clr, b_en, b_we, b_sel, b_rom, b_bank};

  ffwd_ctrl u_dflt (
    .CLK(clk), .RST(rst), .START(start), .BUSY(a_busy), .DONE(a_done),
    .ACC_CLR(a_clr), .ACC_EN(a_en), .WRITE_EN(a_we), .LAYER_SEL(a_sel),
    .ROM_ADDR(a_rom), .BANK_ADDR(a_bank));

  ffwd_ctrl #(.L1_TERMS(1), .L2_TERMS(1), .MAC_LATENCY(0), .LUT_LATENCY(0)) u_min (
    .CLK(clk), .RST(rst), .START(start), .BUSY(b_busy), .DONE(b_done),
    .ACC_CLR(b_clr), .ACC_EN(b_en), .WRITE_EN(b_we), .LAYER_SEL(b_sel),
    .ROM_ADDR(b_rom), .BANK_ADDR(b_bank));

  int L1 [2] = '{2, 1};
  int L2 [2] = '{3, 1};
  int ML [2] = '{2, 0};
  int LL [2] = '{1, 0};

  bit act [2];
  int t [2];
  int acc [2];
  int ndone [2];
  int done_edge [2];
  int edge_n, s_edge, base0, base1;
  int nvec, nerr;
  bit found;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @edge %0d", tag, got, exp, edge_n);
    end
  endtask

  // Offset of the DONE cycle inside a pass (offset 0 = layer-1 clear).
  function automatic int done_off(input int c);
    return 1 + L1[c] + ML[c] + LL[c] + 1 + 1 + L2[c] + ML[c];
  endfunction

  function automatic logic [13:0] exp_out(input int c, input bit a, input int tt);
    int w, c2, m2, d;
    bit l1m, l2m;
    logic [3:0] rom, bank;
    w  = 1 + L1[c] + ML[c] + LL[c];
    c2 = w + 1;
    m2 = c2 + 1;
    d  = done_off(c);
    l1m = (tt >= 1) && (tt <= L1[c]);
    l2m = (tt >= m2) && (tt < m2 + L2[c]);
    rom  = l1m ? 4'(tt - 1) : l2m ? 4'(L1[c] + tt - m2) : 4'd0;
    bank = l2m ? 4'(tt - m2) : 4'd0;
    if (!a) return 14'd0;
    return {tt < d, tt == d, (tt == 0) || (tt == c2), l1m || l2m, tt == w, tt >= c2, rom, bank};
  endfunction

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("outs%0d", c), obs[c], exp_out(c, act[c], t[c]));
      chk($sformatf("en_clr%0d", c), obs[c][10] & obs[c][11], 0);
      chk($sformatf("we_en%0d", c), obs[c][9] & obs[c][10], 0);
      if (obs[c][12]) begin
        ndone[c]++;
        done_edge[c] = edge_n;
      end
    end
  endtask

  task automatic cyc(input bit st);
    start = st;
    @(posedge clk);
    edge_n++;
    for (int c = 0; c < 2; c++) begin
      if (rst) act[c] = 1'b0;
      else if (!act[c]) begin
        if (st) begin act[c] = 1'b1; t[c] = 0; acc[c]++; end
      end else if (t[c] < done_off(c)) t[c]++;
      else if (st) begin t[c] = 0; acc[c]++; end
      else act[c] = 1'b0;
    end
    #2;
    check_all();
  endtask

  initial begin
    nvec = 0; nerr = 0; edge_n = 0;
    rst = 1'b1; start = 1'b0;
    for (int c = 0; c < 2; c++) begin act[c] = 0; t[c] = 0; acc[c] = 0; ndone[c] = 0; done_edge[c] = -100; end
    repeat (3) cyc(0);
    rst = 1'b0;
    repeat (2) cyc(0);

    // single pass
    s_edge = edge_n + 1;
    cyc(1);
    repeat (20) cyc(0);
    chk("dflt_done_lat", done_edge[0] - s_edge, 13);
    chk("min_done_lat", done_edge[1] - s_edge, 5);

    // START held: back-to-back passes, no idle bubble
    base0 = ndone[0]; base1 = ndone[1];
    repeat (40) cyc(1);
    repeat (20) cyc(0);
    chk("b2b_dones0", ndone[0] - base0, 3);
    chk("b2b_dones1", ndone[1] - base1, 7);

    // asynchronous reset during layer-2 MAC
    cyc(1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(0);
      if (obs[0][10] && obs[0][8]) found = 1'b1;
    end
    chk("l2mac_reached", found, 1);
    base0 = ndone[0];
    rst = 1'b1;
    act[0] = 1'b0; act[1] = 1'b0;
    #1;
    chk("rst_async0", obs[0], 0);
    chk("rst_async1", obs[1], 0);
    repeat (2) cyc(0);
    rst = 1'b0;
    cyc(0);
    chk("rst_no_done", ndone[0] - base0, 0);
    s_edge = edge_n + 1;
    cyc(1);
    repeat (16) cyc(0);
    chk("post_rst_lat", done_edge[0] - s_edge, 13);

    // random START traffic
    for (int c = 0; c < 2; c++) begin acc[c] = 0; ndone[c] = 0; end
    repeat (5000) cyc($urandom_range(0, 3) == 0);
    repeat (20) cyc(0);
    chk("dones_vs_starts0", ndone[0], acc[0]);
    chk("dones_vs_starts1", ndone[1], acc[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
